// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - received-word output bundle of the UART RX frame controller
interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stop_err;

    modport master (
        output P_DATA,
        output data_valid,
        output par_err,
        output stop_err
    );

    modport slave (
        input P_DATA,
        input data_valid,
        input par_err,
        input stop_err
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART RX frame controller; UART_RX_SYNC_EN adds a 2-flop input synchronizer
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8,
    parameter int EDGE_W     = 4,
    parameter int BIT_W      = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX_IN,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic [EDGE_W-1:0] edge_cnt,
    input  logic [BIT_W-1:0]  bit_cnt,
    output logic              cnt_en,
    uart_rx_ctrl_if.master    rx_out
);

    localparam logic [EDGE_W-1:0] EDGE_S0   = EDGE_W'(OVERSAMPLE / 2 - 1);
    localparam logic [EDGE_W-1:0] EDGE_S1   = EDGE_W'(OVERSAMPLE / 2);
    localparam logic [EDGE_W-1:0] EDGE_S2   = EDGE_W'(OVERSAMPLE / 2 + 1);
    localparam logic [EDGE_W-1:0] EDGE_EVAL = EDGE_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic                  rx_line;
    logic [2:0]            sample_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  data_valid_q;
    logic                  par_err_q;
    logic                  stop_err_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  bit_val;
    logic                  eval;
    logic                  start_det;
    logic                  shift_en;
    logic                  par_chk;
    logic                  stop_chk;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RX_IN};
        end
    end

    assign rx_line = sync_q[1];
`else
    assign rx_line = RX_IN;
`endif

    assign bit_val = (sample_q[0] & sample_q[1]) | (sample_q[0] & sample_q[2]) |
                     (sample_q[1] & sample_q[2]);
    assign eval    = (edge_cnt == EDGE_EVAL);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_en    = 1'b1;
        start_det = 1'b0;
        shift_en  = 1'b0;
        par_chk   = 1'b0;
        stop_chk  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_en = 1'b0;
                if (!rx_line) begin
                    state_d   = START;
                    start_det = 1'b1;
                end
            end
            START: begin
                // A start bit that samples high was line noise; drop it silently.
                if (eval) begin
                    state_d = bit_val ? IDLE : DATA;
                end
            end
            DATA: begin
                if (eval) begin
                    shift_en = 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (eval) begin
                    par_chk = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (eval) begin
                    stop_chk = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sample_q     <= 3'b111;
            shift_q      <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            if (cnt_en) begin
                if (edge_cnt == EDGE_S0) sample_q[0] <= rx_line;
                if (edge_cnt == EDGE_S1) sample_q[1] <= rx_line;
                if (edge_cnt == EDGE_S2) sample_q[2] <= rx_line;
            end
            // Frame format is frozen at start so mid-frame register writes cannot corrupt it.
            if (start_det) begin
                par_en_q   <= PAR_EN;
                par_typ_q  <= PAR_TYP;
                par_err_q  <= 1'b0;
                stop_err_q <= 1'b0;
            end
            if (shift_en) begin
                shift_q <= {bit_val, shift_q[DATA_WIDTH-1:1]};
            end
            if (par_chk) begin
                par_err_q <= (bit_val != ((^shift_q) ^ par_typ_q));
            end
            if (stop_chk) begin
                stop_err_q <= ~bit_val;
                if (bit_val && !par_err_q) begin
                    p_data_q     <= shift_q;
                    data_valid_q <= 1'b1;
                end
            end
        end
    end

    assign rx_out.P_DATA     = p_data_q;
    assign rx_out.data_valid = data_valid_q;
    assign rx_out.par_err    = par_err_q;
    assign rx_out.stop_err   = stop_err_q;

endmodule
